// File: rtl/button_event_decoder.sv
// ---------------------------------------------------------------------------
// button_event_decoder
//
// Classifies each press of the debounced push-button into short-press,
// long-press and auto-repeat events for the digital clock's set/mode
// controller. The whole block runs in the clk_in domain.
//
// The hold time is measured in ticks. A free-running prescaler produces one
// tick every TICK_DIV clk_in cycles. A press that is released before
// LONG_TICKS ticks is a short press. A hold that reaches LONG_TICKS ticks is
// a long press. After a long press, a repeat event follows every
// REPEAT_TICKS ticks while the button is still held.
//
// Build option:
//   BTN_AUTOREPEAT_EN - when defined, the repeat counter and repeat_pulse
//                       generation are present. When undefined, repeat_pulse
//                       is tied to 0, and LONG is left only on release.
//
// Parameters:
//   TICK_DIV     clk_in cycles per hold tick (>= 2)
//   LONG_TICKS   ticks of continuous hold before long_press (>= 2)
//   REPEAT_TICKS ticks between repeat_pulse events (>= 1)
//   CNT_W        width of the prescaler and the hold/repeat counters
//
// Ports:
//   clk_in        in   system clock; all logic on the rising edge
//   rst_n         in   asynchronous active-low reset
//   btn_level     in   debounced button level, 1 = pressed (asynchronous)
//   short_press   out  1-cycle pulse on release of a short press
//   long_press    out  1-cycle pulse when the hold reaches LONG_TICKS
//   repeat_pulse  out  1-cycle pulse every REPEAT_TICKS after long_press
//   held          out  level, 1 while the press FSM is in PRESSED or LONG
// ---------------------------------------------------------------------------
module button_event_decoder #(
  parameter int TICK_DIV     = 100000,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 250,
  parameter int CNT_W        = 17
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic btn_level,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  // Reject configurations the counters cannot represent.
  if (TICK_DIV < 2 || LONG_TICKS < 2 || REPEAT_TICKS < 1 ||
      longint'(TICK_DIV - 1) >= (longint'(1) << CNT_W) ||
      longint'(LONG_TICKS) >= (longint'(1) << CNT_W) ||
      longint'(REPEAT_TICKS) >= (longint'(1) << CNT_W)) begin : g_bad_cfg
    $error("button_event_decoder: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_LONG    = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Input synchronizer (btn_level is asynchronous to clk_in)
  // -------------------------------------------------------------------------
  logic btn_meta;
  logic btn_s;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      btn_meta <= btn_level;
      btn_s    <= btn_meta;
    end
  end

  // -------------------------------------------------------------------------
  // Tick prescaler: free-running, cleared only by reset, so the tick phase
  // relative to a press is arbitrary. That phase is what spreads the
  // long_press latency across one tick period.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] pre_cnt;
  logic             tick;

  assign tick = (pre_cnt == DIV_LAST);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + CNT_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Press FSM and its counters
  // -------------------------------------------------------------------------
  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nxt;
  logic             hold_clr;
  logic             hold_inc;
  logic             short_ev;
  logic             long_ev;
  logic             rep_ev;
  // Release seen one edge earlier; delayed so short_press lines up with the
  // falling edge of held, which is itself one register behind the state.
  logic             short_q;

  assign hold_nxt = hold_cnt + CNT_ONE;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_TICKS);

  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_nxt;
  logic             rep_clr;
  logic             rep_inc;

  assign rep_nxt = rep_cnt + CNT_ONE;
`endif

  // State register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      short_q <= 1'b0;
    end else begin
      state   <= next_state;
      short_q <= short_ev;
    end
  end

  // Hold counter: stops at LONG_TICKS because the FSM leaves PRESSED there.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (hold_clr) begin
      hold_cnt <= '0;
    end else if (hold_inc) begin
      hold_cnt <= hold_nxt;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  // Repeat counter: cleared on entry to LONG and on every repeat event,
  // so it never exceeds REPEAT_TICKS.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (rep_clr) begin
      rep_cnt <= '0;
    end else if (rep_inc) begin
      rep_cnt <= rep_nxt;
    end
  end
`endif

  // Next-state logic. Release is tested before the tick in every state, so
  // a release coinciding with the deciding tick suppresses the tick event.
  always_comb begin
    next_state = state;
    hold_clr   = 1'b0;
    hold_inc   = 1'b0;
    short_ev   = 1'b0;
    long_ev    = 1'b0;
    rep_ev     = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rep_clr    = 1'b0;
    rep_inc    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (btn_s) begin
          next_state = S_PRESSED;
          hold_clr   = 1'b1;
        end
      end
      S_PRESSED: begin
        if (!btn_s) begin
          next_state = S_IDLE;
          short_ev   = 1'b1;
        end else if (tick) begin
          hold_inc = 1'b1;
          if (hold_nxt == LONG_LAST) begin
            next_state = S_LONG;
            long_ev    = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            rep_clr    = 1'b1;
`endif
          end
        end
      end
      S_LONG: begin
        if (!btn_s) begin
          next_state = S_IDLE;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (tick) begin
          if (rep_nxt == REP_LAST) begin
            rep_ev  = 1'b1;
            rep_clr = 1'b1;
          end else begin
            rep_inc = 1'b1;
          end
        end
`endif
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: next values for the output registers
  // -------------------------------------------------------------------------
  logic held_d;
  logic short_d;
  logic long_d;
  logic rep_d;

  always_comb begin
    held_d  = (state != S_IDLE);
    short_d = short_q;
    long_d  = long_ev;
    rep_d   = rep_ev;
  end

  // Output registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      held        <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      held        <= held_d;
      short_press <= short_d;
      long_press  <= long_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= rep_d;
    end
  end
`else
  // Auto-repeat is not built; rep_ev is never raised in this configuration.
  assign repeat_pulse = 1'b0;

  logic unused_rep;
  assign unused_rep = rep_d;
`endif

endmodule
